// File: rtl/mips_mc_pkg.sv
// Shared types and constants for the multicycle MIPS controller:
// state encoding, opcode/funct decodes and ALU operation codes.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        INIT      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADR   = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        R_EXEC    = 4'd7,
        R_WB      = 4'd8,
        I_EXEC    = 4'd9,
        I_WB      = 4'd10,
        BRANCH    = 4'd11,
        JUMP      = 4'd12,
        JR        = 4'd13,
        HALT      = 4'd15
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // R-type functs that have an ALU operation and a register write-back
    function automatic logic is_r_alu(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
               (fn == FN_OR)  || (fn == FN_SLT);
    endfunction

endpackage

// File: rtl/mips_mc_controller_if.sv
// Controller <-> datapath bundle: IR fields and zero flag in, control strobes out.
interface mips_mc_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [1:0] reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       IorD;
    logic       ir_write;
    logic       reg_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       mem_read;
    logic       mem_write;

    modport ctrl (
        input  opcode, funct, zero,
        output reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, pc_src,
               IorD, ir_write, reg_write, pc_write, pc_write_cond, mem_read, mem_write
    );

    modport dp (
        output opcode, funct, zero,
        input  reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, pc_src,
               IorD, ir_write, reg_write, pc_write, pc_write_cond, mem_read, mem_write
    );
endinterface

// File: rtl/mips_mc_alu_dec.sv
// ALU operation select from the controller state plus the IR opcode/funct fields.
module mips_mc_alu_dec
    import mips_mc_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_AND;
        case (state)
            FETCH, DECODE, MEM_ADR: alu_ctrl = ALU_ADD;
            R_EXEC: begin
                case (funct)
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            I_EXEC:  alu_ctrl = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
            BRANCH:  alu_ctrl = ALU_SUB;
            default: alu_ctrl = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS main controller FSM; performance counters are built only
// when MIPS_MC_PERF_EN is defined, otherwise the counter ports read 0.
module mips_mc_controller
    import mips_mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    mips_mc_controller_if.ctrl bus,
    output logic               halted,
    output logic [3:0]         state_dbg,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_W-1:0]   instr_count
);

    state_t state_reg, state_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= INIT;
        else      state_reg <= state_next;
    end

    mips_mc_alu_dec u_alu_dec (
        .state    (state_reg),
        .opcode   (bus.opcode),
        .funct    (bus.funct),
        .alu_ctrl (bus.alu_ctrl)
    );

    always_comb begin
        state_next        = state_reg;
        bus.reg_dst       = 2'b00;
        bus.mem_to_reg    = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.pc_src        = 2'b00;
        bus.IorD          = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        case (state_reg)
            INIT: state_next = FETCH;
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.ir_write  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.pc_write  = 1'b1;
                state_next    = DECODE;
            end
            DECODE: begin
                bus.alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW:     state_next = MEM_ADR;
                    OP_R:             state_next = (bus.funct == FN_JR) ? JR : R_EXEC;
                    OP_ADDI, OP_SLTI: state_next = I_EXEC;
                    OP_BEQ, OP_BNE:   state_next = BRANCH;
                    OP_J:             state_next = JUMP;
                    default:          state_next = HALT;
                endcase
            end
            MEM_ADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_next    = (bus.opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                bus.IorD     = 1'b1;
                bus.mem_read = 1'b1;
                state_next   = MEM_WB;
            end
            MEM_WB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
                state_next     = FETCH;
            end
            MEM_WRITE: begin
                bus.IorD      = 1'b1;
                bus.mem_write = 1'b1;
                state_next    = FETCH;
            end
            R_EXEC: begin
                bus.alu_src_a = 1'b1;
                state_next    = is_r_alu(bus.funct) ? R_WB : HALT;
            end
            R_WB: begin
                bus.reg_dst   = 2'b01;
                bus.reg_write = 1'b1;
                state_next    = FETCH;
            end
            I_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_next    = I_WB;
            end
            I_WB: begin
                bus.reg_write = 1'b1;
                state_next    = FETCH;
            end
            BRANCH: begin
                // bne is the one Mealy output: it inverts zero directly into pc_write
                bus.alu_src_a     = 1'b1;
                bus.pc_src        = 2'b10;
                bus.pc_write_cond = (bus.opcode == OP_BEQ);
                bus.pc_write      = (bus.opcode == OP_BNE) && !bus.zero;
                state_next        = FETCH;
            end
            JUMP: begin
                bus.pc_src   = 2'b01;
                bus.pc_write = 1'b1;
                state_next   = FETCH;
            end
            JR: begin
                bus.pc_src   = 2'b11;
                bus.pc_write = 1'b1;
                state_next   = FETCH;
            end
            HALT:    state_next = HALT;
            default: state_next = HALT;
        endcase
    end

    assign halted    = (state_reg == HALT);
    assign state_dbg = state_reg;

`ifdef MIPS_MC_PERF_EN
    logic [CNT_W-1:0] cycle_count_reg, instr_count_reg;

    // An instruction completes on the edge that returns to FETCH, except the
    // INIT->FETCH edge, which only starts the first one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count_reg <= '0;
            instr_count_reg <= '0;
        end else begin
            if (state_reg != INIT && state_reg != HALT)
                cycle_count_reg <= cycle_count_reg + 1'b1;
            if (state_next == FETCH && state_reg != INIT)
                instr_count_reg <= instr_count_reg + 1'b1;
        end
    end

    assign cycle_count = cycle_count_reg;
    assign instr_count = instr_count_reg;
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: walks each instruction class state by
// state against hand-written control words; counter checks follow MIPS_MC_PERF_EN.
module tb_mips_mc_controller;

    localparam int CNT_W = 32;
`ifdef MIPS_MC_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [3:0] S_INIT = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,
                           S_MADR = 4'd3,  S_MRD   = 4'd4,  S_MWB    = 4'd5,
                           S_MWR  = 4'd6,  S_REX   = 4'd7,  S_RWB    = 4'd8,
                           S_IEX  = 4'd9,  S_IWB   = 4'd10, S_BR     = 4'd11,
                           S_J    = 4'd12, S_JR    = 4'd13, S_HALT   = 4'd15;

    // Control word: reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, pc_src,
    // IorD, ir_write, reg_write, pc_write, pc_write_cond, mem_read, mem_write
    localparam logic [17:0] W_ZERO   = 18'b00_0_0_00_000_00_0000000;
    localparam logic [17:0] W_FETCH  = 18'b00_0_0_01_010_00_0101010;
    localparam logic [17:0] W_DEC    = 18'b00_0_0_11_010_00_0000000;
    localparam logic [17:0] W_MADR   = 18'b00_0_1_10_010_00_0000000;
    localparam logic [17:0] W_MRD    = 18'b00_0_0_00_000_00_1000010;
    localparam logic [17:0] W_MWB    = 18'b00_1_0_00_000_00_0010000;
    localparam logic [17:0] W_MWR    = 18'b00_0_0_00_000_00_1000001;
    localparam logic [17:0] W_RADD   = 18'b00_0_1_00_010_00_0000000;
    localparam logic [17:0] W_RSUB   = 18'b00_0_1_00_110_00_0000000;
    localparam logic [17:0] W_RWB    = 18'b01_0_0_00_000_00_0010000;
    localparam logic [17:0] W_SLTI   = 18'b00_0_1_10_111_00_0000000;
    localparam logic [17:0] W_IWB    = 18'b00_0_0_00_000_00_0010000;
    localparam logic [17:0] W_BEQ    = 18'b00_0_1_00_110_10_0000100;
    localparam logic [17:0] W_BNE_T  = 18'b00_0_1_00_110_10_0001000;
    localparam logic [17:0] W_BNE_NT = 18'b00_0_1_00_110_10_0000000;
    localparam logic [17:0] W_JUMP   = 18'b00_0_0_00_000_01_0001000;
    localparam logic [17:0] W_JRW    = 18'b00_0_0_00_000_11_0001000;

    logic             clk;
    logic             rst;
    logic             halted;
    logic [3:0]       state_dbg;
    logic [CNT_W-1:0] cycle_count, instr_count;
    logic [17:0]      ctl_word;
    int               checks_cnt;
    int               errors_cnt;

    mips_mc_controller_if bus ();

    mips_mc_controller #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.ctrl),
        .halted      (halted),
        .state_dbg   (state_dbg),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    assign ctl_word = {bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
                       bus.alu_ctrl, bus.pc_src, bus.IorD, bus.ir_write, bus.reg_write,
                       bus.pc_write, bus.pc_write_cond, bus.mem_read, bus.mem_write};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance to the next falling edge and check state, halted and (optionally) the control word
    task automatic step(input string tag, input logic [3:0] st, input logic chk_w,
                        input logic [17:0] w);
        @(negedge clk);
        check({tag, "/state"}, 64'(state_dbg), 64'(st));
        check({tag, "/halted"}, 64'(halted), 64'(st == S_HALT));
        if (chk_w) check({tag, "/ctl"}, 64'(ctl_word), 64'(w));
    endtask

    task automatic set_ir(input logic [5:0] op, input logic [5:0] fn, input logic z);
        bus.opcode = op;
        bus.funct  = fn;
        bus.zero   = z;
    endtask

    task automatic reset_release;
        @(posedge clk);
        #1 rst = 1'b1;
        step("init", S_INIT, 1'b1, W_ZERO);
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst = 1'b0;
        set_ir(6'b000000, 6'b000000, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst/state", 64'(state_dbg), 64'(S_INIT));
        check("rst/ctl", 64'(ctl_word), 64'(W_ZERO));
        check("rst/halted", 64'(halted), 64'd0);
        check("rst/cyc", 64'(cycle_count), 64'd0);
        check("rst/ins", 64'(instr_count), 64'd0);
        reset_release();

        // lw, sw, add, beq back to back: 5+4+4+3 = 16 cycles, 4 instructions
        set_ir(6'b100011, 6'b000000, 1'b0);
        step("lw", S_FETCH, 1'b1, W_FETCH);
        step("lw", S_DECODE, 1'b1, W_DEC);
        step("lw", S_MADR, 1'b1, W_MADR);
        step("lw", S_MRD, 1'b1, W_MRD);
        step("lw", S_MWB, 1'b1, W_MWB);
        set_ir(6'b101011, 6'b000000, 1'b0);
        step("sw", S_FETCH, 1'b1, W_FETCH);
        step("sw", S_DECODE, 1'b1, W_DEC);
        step("sw", S_MADR, 1'b1, W_MADR);
        step("sw", S_MWR, 1'b1, W_MWR);
        set_ir(6'b000000, 6'b100000, 1'b0);
        step("add", S_FETCH, 1'b1, W_FETCH);
        step("add", S_DECODE, 1'b1, W_DEC);
        step("add", S_REX, 1'b1, W_RADD);
        step("add", S_RWB, 1'b1, W_RWB);
        set_ir(6'b000100, 6'b000000, 1'b0);
        step("beq", S_FETCH, 1'b1, W_FETCH);
        step("beq", S_DECODE, 1'b1, W_DEC);
        step("beq", S_BR, 1'b1, W_BEQ);
        set_ir(6'b000000, 6'b100010, 1'b0);
        step("sub", S_FETCH, 1'b1, W_FETCH);
        check("perf/cyc", 64'(cycle_count), PERF ? 64'd16 : 64'd0);
        check("perf/ins", 64'(instr_count), PERF ? 64'd4 : 64'd0);
        step("sub", S_DECODE, 1'b1, W_DEC);
        step("sub", S_REX, 1'b1, W_RSUB);
        step("sub", S_RWB, 1'b1, W_RWB);

        set_ir(6'b001010, 6'b000000, 1'b0);
        step("slti", S_FETCH, 1'b1, W_FETCH);
        step("slti", S_DECODE, 1'b1, W_DEC);
        step("slti", S_IEX, 1'b1, W_SLTI);
        step("slti", S_IWB, 1'b1, W_IWB);

        set_ir(6'b000101, 6'b000000, 1'b1);
        step("bne_z1", S_FETCH, 1'b1, W_FETCH);
        step("bne_z1", S_DECODE, 1'b1, W_DEC);
        step("bne_z1", S_BR, 1'b1, W_BNE_NT);
        set_ir(6'b000101, 6'b000000, 1'b0);
        step("bne_z0", S_FETCH, 1'b1, W_FETCH);
        step("bne_z0", S_DECODE, 1'b1, W_DEC);
        step("bne_z0", S_BR, 1'b1, W_BNE_T);

        set_ir(6'b000010, 6'b000000, 1'b0);
        step("j", S_FETCH, 1'b1, W_FETCH);
        step("j", S_DECODE, 1'b1, W_DEC);
        step("j", S_J, 1'b1, W_JUMP);
        set_ir(6'b000000, 6'b001000, 1'b0);
        step("jr", S_FETCH, 1'b1, W_FETCH);
        step("jr", S_DECODE, 1'b1, W_DEC);
        step("jr", S_JR, 1'b1, W_JRW);

        // Reset asserted in the middle of MEM_READ
        set_ir(6'b100011, 6'b000000, 1'b0);
        step("lw2", S_FETCH, 1'b1, W_FETCH);
        step("lw2", S_DECODE, 1'b1, W_DEC);
        step("lw2", S_MADR, 1'b1, W_MADR);
        step("lw2", S_MRD, 1'b1, W_MRD);
        rst = 1'b0;
        #1;
        check("midrst/state", 64'(state_dbg), 64'(S_INIT));
        check("midrst/ctl", 64'(ctl_word), 64'(W_ZERO));
        check("midrst/cyc", 64'(cycle_count), 64'd0);
        check("midrst/ins", 64'(instr_count), 64'd0);
        reset_release();

        // Unsupported funct halts after R_EXEC and stays halted
        set_ir(6'b000000, 6'b111111, 1'b0);
        step("badfn", S_FETCH, 1'b1, W_FETCH);
        step("badfn", S_DECODE, 1'b1, W_DEC);
        step("badfn", S_REX, 1'b0, W_ZERO);
        for (int i = 0; i < 10; i++) step("badfn_halt", S_HALT, 1'b1, W_ZERO);
        check("halt/cyc", 64'(cycle_count), PERF ? 64'd3 : 64'd0);
        check("halt/ins", 64'(instr_count), 64'd0);

        // Unknown opcode halts straight from DECODE
        rst = 1'b0;
        reset_release();
        set_ir(6'b111111, 6'b000000, 1'b0);
        step("badop", S_FETCH, 1'b1, W_FETCH);
        step("badop", S_DECODE, 1'b1, W_DEC);
        step("badop_halt", S_HALT, 1'b1, W_ZERO);
        step("badop_halt", S_HALT, 1'b1, W_ZERO);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
